// File: rtl/fusion_writeback_if.sv
// rtl/fusion_writeback_if.sv - stream, BRAM and status signal bundle for fusion_writeback
interface fusion_writeback_if #(
  parameter int INPUT_DATA_WIDTH  = 128,
  parameter int PIX_WIDTH         = 32,
  parameter int ADDR_WIDTH        = 17,
  parameter int LOG2_NO_OF_IMAGES = 4
);
  logic                         s_axis_tvalid;
  logic [INPUT_DATA_WIDTH-1:0]  s_axis_tdata;
  logic                         s_axis_tlast;
  logic                         s_axis_tready;

  logic                         avg_bram_we;
  logic [ADDR_WIDTH-1:0]        avg_bram_addr;
  logic [PIX_WIDTH-1:0]         avg_bram_wdata;
  logic                         fused_bram_we;
  logic [ADDR_WIDTH-1:0]        fused_bram_addr;
  logic [PIX_WIDTH-1:0]         fused_bram_wdata;

  logic                         m_axis_tvalid;
  logic [PIX_WIDTH-1:0]         m_axis_tdata;
  logic                         m_axis_tlast;
  logic                         m_axis_tready;

  logic [LOG2_NO_OF_IMAGES-1:0] frame_idx;
  logic                         frame_done;
  logic                         tlast_err;

  // Environment side: fusion core source, DDR writer sink, BRAM/status observer
  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready,
    input  avg_bram_we, avg_bram_addr, avg_bram_wdata,
    input  fused_bram_we, fused_bram_addr, fused_bram_wdata,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tlast,
    input  frame_idx, frame_done, tlast_err
  );

  // Write-back block side
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready,
    output avg_bram_we, avg_bram_addr, avg_bram_wdata,
    output fused_bram_we, fused_bram_addr, fused_bram_wdata,
    output m_axis_tvalid, m_axis_tdata, m_axis_tlast,
    output frame_idx, frame_done, tlast_err
  );
endinterface

// File: rtl/fusion_writeback.sv
// rtl/fusion_writeback.sv - fusion result write-back to BRAM frame stores with periodic AXI-Stream frame output
// Optional feature macro: FUSION_WB_TLAST_CHECK_EN (s_axis_tlast framing check driving tlast_err)
module fusion_writeback #(
  parameter int IM_LEN            = 520,
  parameter int IM_WID            = 520,
  parameter int NO_IMAGES         = 16,
  parameter int LOG2_NO_OF_IMAGES = 4,
  parameter int NO_PARALLEL_UNITS = 4,
  parameter int DATA_WIDTH        = 8,
  parameter int INPUT_DATA_WIDTH  = 128,
  parameter int ADDR_WIDTH        = 17
) (
  input logic               axi_clk,
  input logic               axi_areset,
  fusion_writeback_if.slave wb
);
  localparam int P     = NO_PARALLEL_UNITS * DATA_WIDTH;
  localparam int BEATS = IM_LEN * IM_WID / NO_PARALLEL_UNITS;
  localparam logic [ADDR_WIDTH-1:0]        LAST_BEAT      = (ADDR_WIDTH)'(BEATS - 1);
  localparam logic [LOG2_NO_OF_IMAGES-1:0] WRBK_FRAME     = (LOG2_NO_OF_IMAGES)'(NO_IMAGES - 1);
  localparam logic [LOG2_NO_OF_IMAGES-1:0] PRE_WRBK_FRAME = (LOG2_NO_OF_IMAGES)'(NO_IMAGES - 2);

  typedef enum logic [1:0] {ST_ACCUM, ST_WRBK, ST_DRAIN} state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic                         r_run;
  logic [ADDR_WIDTH-1:0]        r_beat_cnt;
  logic [LOG2_NO_OF_IMAGES-1:0] r_frame_idx;
  logic                         r_we;
  logic [ADDR_WIDTH-1:0]        r_addr;
  logic [P-1:0]                 r_avg_wdata;
  logic [P-1:0]                 r_fused_wdata;
  logic                         r_frame_done;
  logic                         r_m_tvalid;
  logic [P-1:0]                 r_m_tdata;
  logic                         r_m_tlast;
  logic                         r_tlast_err;

  logic                         w_s_tready;
  logic                         w_accept;
  logic                         w_last_beat;
  logic                         w_m_hs;
  logic                         w_load;
  logic                         w_out_busy_nxt;

  assign w_accept       = wb.s_axis_tvalid & w_s_tready;
  assign w_last_beat    = (r_beat_cnt == LAST_BEAT);
  assign w_m_hs         = r_m_tvalid & wb.m_axis_tready;
  assign w_load         = w_accept & (r_state == ST_WRBK);
  assign w_out_busy_nxt = w_load | (r_m_tvalid & ~w_m_hs);

  // Input ready: free-running in ACCUM, gated by the single output slot in WRBK, closed in DRAIN
  always_comb begin
    w_s_tready = 1'b0;
    case (r_state)
      ST_ACCUM: w_s_tready = r_run;
      ST_WRBK:  w_s_tready = ~r_m_tvalid | wb.m_axis_tready;
      default:  w_s_tready = 1'b0;
    endcase
  end

  // Next state: enter WRBK for the last frame of the period, leave once its last beat is out
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACCUM: begin
        if (w_accept && w_last_beat && (r_frame_idx == PRE_WRBK_FRAME)) w_state_nxt = ST_WRBK;
      end
      ST_WRBK: begin
        if (w_accept && w_last_beat) w_state_nxt = w_out_busy_nxt ? ST_DRAIN : ST_ACCUM;
      end
      ST_DRAIN: begin
        if (w_m_hs) w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  // State register
  always_ff @(posedge axi_clk or posedge axi_areset) begin
    if (axi_areset) r_state <= ST_ACCUM;
    else            r_state <= w_state_nxt;
  end

  // Hold input ready low during reset and open it on the first edge after release
  always_ff @(posedge axi_clk or posedge axi_areset) begin
    if (axi_areset) r_run <= 1'b0;
    else            r_run <= 1'b1;
  end

  // Pixel-group and frame counters advance on accepted beats only
  always_ff @(posedge axi_clk or posedge axi_areset) begin
    if (axi_areset) begin
      r_beat_cnt  <= '0;
      r_frame_idx <= '0;
    end else if (w_accept) begin
      if (w_last_beat) begin
        r_beat_cnt  <= '0;
        r_frame_idx <= (r_frame_idx == WRBK_FRAME) ? '0 : r_frame_idx + 1'b1;
      end else begin
        r_beat_cnt  <= r_beat_cnt + 1'b1;
      end
    end
  end

  // BRAM write port: one registered write per accepted beat into both stores
  always_ff @(posedge axi_clk or posedge axi_areset) begin
    if (axi_areset) begin
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_avg_wdata   <= '0;
      r_fused_wdata <= '0;
    end else begin
      r_we <= w_accept;
      if (w_accept) begin
        r_addr        <= r_beat_cnt;
        r_fused_wdata <= wb.s_axis_tdata[P-1:0];
        r_avg_wdata   <= wb.s_axis_tdata[2*P-1:P];
      end
    end
  end

  // Frame-done pulse follows the write cycle of the last pixel group
  always_ff @(posedge axi_clk or posedge axi_areset) begin
    if (axi_areset) r_frame_done <= 1'b0;
    else            r_frame_done <= r_we & (r_addr == LAST_BEAT);
  end

  // Output slot: load on WRBK accepts (may overlap a handshake), empty on handshake alone
  always_ff @(posedge axi_clk or posedge axi_areset) begin
    if (axi_areset) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
    end else if (w_load) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= wb.s_axis_tdata[P-1:0];
      r_m_tlast  <= w_last_beat;
    end else if (w_m_hs) begin
      r_m_tvalid <= 1'b0;
    end
  end

`ifdef FUSION_WB_TLAST_CHECK_EN
  // Sticky framing error: core's tlast must coincide with our own last pixel group
  always_ff @(posedge axi_clk or posedge axi_areset) begin
    if (axi_areset)                                        r_tlast_err <= 1'b0;
    else if (w_accept && (wb.s_axis_tlast != w_last_beat)) r_tlast_err <= 1'b1;
  end
`else
  logic w_unused_tlast;
  assign w_unused_tlast = wb.s_axis_tlast;
  assign r_tlast_err    = 1'b0;
`endif

  generate
    if (INPUT_DATA_WIDTH > 2 * P) begin : g_unused_hi
      logic w_unused_hi;
      assign w_unused_hi = ^wb.s_axis_tdata[INPUT_DATA_WIDTH-1:2*P];
    end
  endgenerate

  assign wb.s_axis_tready    = w_s_tready;
  assign wb.avg_bram_we      = r_we;
  assign wb.fused_bram_we    = r_we;
  assign wb.avg_bram_addr    = r_addr;
  assign wb.fused_bram_addr  = r_addr;
  assign wb.avg_bram_wdata   = r_avg_wdata;
  assign wb.fused_bram_wdata = r_fused_wdata;
  assign wb.m_axis_tvalid    = r_m_tvalid;
  assign wb.m_axis_tdata     = r_m_tdata;
  assign wb.m_axis_tlast     = r_m_tlast;
  assign wb.frame_idx        = r_frame_idx;
  assign wb.frame_done       = r_frame_done;
  assign wb.tlast_err        = r_tlast_err;
endmodule

// File: tb/tb_fusion_writeback.sv
// tb/tb_fusion_writeback.sv - randomized self-checking bench for fusion_writeback
module tb_fusion_writeback;
  localparam int IM_LEN = 4, IM_WID = 4, NPU = 4, NI = 4, LOG2NI = 2, DW = 8, IDW = 128, AW = 4;
  localparam int P     = NPU * DW;
  localparam int BEATS = IM_LEN * IM_WID / NPU;
`ifdef FUSION_WB_TLAST_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic axi_clk    = 1'b0;
  logic axi_areset = 1'b1;
  always #5 axi_clk = ~axi_clk;

  fusion_writeback_if #(.INPUT_DATA_WIDTH(IDW), .PIX_WIDTH(P), .ADDR_WIDTH(AW), .LOG2_NO_OF_IMAGES(LOG2NI)) bus ();

  fusion_writeback #(
    .IM_LEN(IM_LEN), .IM_WID(IM_WID), .NO_IMAGES(NI), .LOG2_NO_OF_IMAGES(LOG2NI),
    .NO_PARALLEL_UNITS(NPU), .DATA_WIDTH(DW), .INPUT_DATA_WIDTH(IDW), .ADDR_WIDTH(AW)
  ) dut (
    .axi_clk(axi_clk),
    .axi_areset(axi_areset),
    .wb(bus)
  );

  typedef struct { logic [AW-1:0] addr; logic [P-1:0] avg; logic [P-1:0] fused; } wr_t;
  typedef struct { logic [P-1:0] data; logic last; } mb_t;

  wr_t  exp_wr[$];
  mb_t  exp_m[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_beats = 0;   // beats accepted since last reset (reference position)
  logic done_pend = 1'b0;
  logic tl_force  = 1'b0;

  function automatic logic [IDW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [LOG2NI-1:0] model_frame();
    return LOG2NI'((n_beats / BEATS) % NI);
  endfunction

  task automatic model_reset();
    exp_wr.delete();
    exp_m.delete();
    n_beats   = 0;
    done_pend = 1'b0;
  endtask

  // One clock: inputs already driven by caller at posedge+1; scoreboard writes and m_axis beats
  task automatic tick(output logic acc, output logic mhs);
    logic done_exp, done_now;
    wr_t  w;
    mb_t  m;
    bus.s_axis_tlast = tl_force | ((n_beats % BEATS) == BEATS - 1);
    #1;
    acc = bus.s_axis_tvalid & bus.s_axis_tready;
    mhs = bus.m_axis_tvalid & bus.m_axis_tready;
    done_now = 1'b0;
    if (bus.m_axis_tvalid) begin
      n_tests++;
      if (exp_m.size() == 0) begin
        n_fail++;
        $display("FAIL m_axis_unexpected: tvalid=1 data=%h, required no pending beat", bus.m_axis_tdata);
      end else if (bus.m_axis_tdata !== exp_m[0].data || bus.m_axis_tlast !== exp_m[0].last) begin
        n_fail++;
        $display("FAIL m_axis_beat: got data=%h last=%b, required data=%h last=%b",
                 bus.m_axis_tdata, bus.m_axis_tlast, exp_m[0].data, exp_m[0].last);
      end
    end
    if (acc) begin
      w.addr  = AW'(n_beats % BEATS);
      w.fused = bus.s_axis_tdata[P-1:0];
      w.avg   = bus.s_axis_tdata[2*P-1:P];
      exp_wr.push_back(w);
      if (((n_beats / BEATS) % NI) == NI - 1) begin
        m.data = w.fused;
        m.last = ((n_beats % BEATS) == BEATS - 1);
        exp_m.push_back(m);
      end
      done_now = ((n_beats % BEATS) == BEATS - 1);
      n_beats++;
    end
    done_exp  = done_pend;
    done_pend = acc & done_now;
    @(posedge axi_clk);
    #1;
    if (mhs && exp_m.size() != 0) void'(exp_m.pop_front());
    n_tests++;
    if (bus.avg_bram_we !== acc || bus.fused_bram_we !== acc) begin
      n_fail++;
      $display("FAIL bram_we: got avg=%b fused=%b, required %b", bus.avg_bram_we, bus.fused_bram_we, acc);
    end
    if (acc) begin
      w = exp_wr.pop_front();
      n_tests++;
      if (bus.avg_bram_addr !== w.addr || bus.fused_bram_addr !== w.addr ||
          bus.avg_bram_wdata !== w.avg || bus.fused_bram_wdata !== w.fused) begin
        n_fail++;
        $display("FAIL bram_write: got addr=%0d/%0d avg=%h fused=%h, required addr=%0d avg=%h fused=%h",
                 bus.avg_bram_addr, bus.fused_bram_addr, bus.avg_bram_wdata, bus.fused_bram_wdata,
                 w.addr, w.avg, w.fused);
      end
    end
    n_tests++;
    if (bus.frame_idx !== model_frame()) begin
      n_fail++;
      $display("FAIL frame_idx: got %0d, required %0d", bus.frame_idx, model_frame());
    end
    n_tests++;
    if (bus.frame_done !== done_exp) begin
      n_fail++;
      $display("FAIL frame_done: got %b, required %b", bus.frame_done, done_exp);
    end
  endtask

  task automatic test_reset();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = 1'b1;
    axi_areset = 1'b1;
    model_reset();
    repeat (2) @(posedge axi_clk);
    #1;
    n_tests++;
    if (bus.s_axis_tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_tready: got %b, required 0", bus.s_axis_tready);
    end
    n_tests++;
    if ({bus.avg_bram_we, bus.fused_bram_we, bus.avg_bram_addr, bus.avg_bram_wdata, bus.fused_bram_wdata,
         bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, bus.frame_idx, bus.frame_done, bus.tlast_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
    axi_areset = 1'b0;
    @(posedge axi_clk);
    #1;
    n_tests++;
    if (bus.s_axis_tready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_tready: got %b, required 1", bus.s_axis_tready);
    end
  endtask

  task automatic test_continuous();
    logic acc, mhs;
    int   m_cnt = 0, tl_cnt = 0, cyc = 0;
    bus.m_axis_tready = 1'b1;
    while ((n_beats < 16 || exp_m.size() != 0) && cyc < 60) begin
      bus.s_axis_tvalid = (n_beats < 16);
      bus.s_axis_tdata  = rand_data();
      if (bus.m_axis_tvalid && bus.m_axis_tlast) tl_cnt++;
      tick(acc, mhs);
      if (mhs) m_cnt++;
      cyc++;
    end
    bus.s_axis_tvalid = 1'b0;
    n_tests++;
    if (n_beats != 16 || exp_m.size() != 0) begin
      n_fail++; $display("FAIL cont_timeout: got beats=%0d pending=%0d, required 16 and 0", n_beats, exp_m.size());
    end
    n_tests++;
    if (m_cnt != 4 || tl_cnt != 1) begin
      n_fail++; $display("FAIL cont_m_count: got beats=%0d tlast=%0d, required 4 and 1", m_cnt, tl_cnt);
    end
    n_tests++;
    if (bus.tlast_err !== 1'b0) begin
      n_fail++; $display("FAIL cont_tlast_err: got %b, required 0", bus.tlast_err);
    end
  endtask

  task automatic test_data_split();
    logic acc, mhs;
    logic [IDW-1:0] d;
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = rand_data();
      tick(acc, mhs);
    end
    d = rand_data();
    d[2*P-1:0] = 64'hA1A2_A3A4_F1F2_F3F4;
    bus.s_axis_tdata = d;
    tick(acc, mhs);
    n_tests++;
    if (acc !== 1'b1 || bus.avg_bram_wdata !== 32'hA1A2A3A4 || bus.fused_bram_wdata !== 32'hF1F2F3F4 ||
        bus.avg_bram_addr !== AW'(2) || bus.fused_bram_addr !== AW'(2)) begin
      n_fail++;
      $display("FAIL split: got acc=%b avg=%h fused=%h addr=%0d, required 1 a1a2a3a4 f1f2f3f4 2",
               acc, bus.avg_bram_wdata, bus.fused_bram_wdata, bus.avg_bram_addr);
    end
    bus.s_axis_tdata = rand_data();
    tick(acc, mhs);
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic test_stall();
    logic acc, mhs;
    int   cyc = 0;
    bus.m_axis_tready = 1'b1;
    while (n_beats < 28 && cyc < 20) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = rand_data();
      tick(acc, mhs);
      cyc++;
    end
    n_tests++;
    if (bus.frame_idx !== LOG2NI'(3)) begin
      n_fail++; $display("FAIL stall_enter: got frame_idx=%0d, required 3", bus.frame_idx);
    end
    bus.m_axis_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = rand_data();
      tick(acc, mhs);
      n_tests++;
      if (acc !== (c == 0)) begin
        n_fail++; $display("FAIL stall_accept c=%0d: got %b, required %b", c, acc, (c == 0));
      end
    end
    bus.m_axis_tready = 1'b1;
    cyc = 0;
    while ((n_beats < 32 || exp_m.size() != 0) && cyc < 30) begin
      bus.s_axis_tvalid = (n_beats < 32);
      bus.s_axis_tdata  = rand_data();
      tick(acc, mhs);
      cyc++;
    end
    bus.s_axis_tvalid = 1'b0;
    #1;
    n_tests++;
    if (n_beats != 32 || exp_m.size() != 0 || bus.s_axis_tready !== 1'b1 || bus.frame_idx !== '0) begin
      n_fail++;
      $display("FAIL stall_drain: got beats=%0d pending=%0d tready=%b frame=%0d, required 32 0 1 0",
               n_beats, exp_m.size(), bus.s_axis_tready, bus.frame_idx);
    end
  endtask

  task automatic test_back_to_back();
    logic acc, mhs;
    int   cyc = 0;
    for (int i = 0; i < 120; i++) begin
      bus.s_axis_tvalid = ($urandom_range(0, 3) != 0);
      bus.m_axis_tready = ($urandom_range(0, 3) != 0);
      bus.s_axis_tdata  = rand_data();
      tick(acc, mhs);
    end
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    while (exp_m.size() != 0 && cyc < 10) begin
      tick(acc, mhs);
      cyc++;
    end
    n_tests++;
    if (exp_m.size() != 0) begin
      n_fail++; $display("FAIL b2b_drain: got %0d pending beats, required 0", exp_m.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic acc, mhs;
    int   cyc = 0;
    bus.m_axis_tready = 1'b1;
    while ((n_beats % 16) != 15 && cyc < 60) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = rand_data();
      tick(acc, mhs);
      cyc++;
    end
    bus.s_axis_tvalid = 1'b0;
    n_tests++;
    if ((n_beats % 16) != 15 || bus.m_axis_tvalid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_setup: got pos=%0d tvalid=%b, required 15 1", n_beats % 16, bus.m_axis_tvalid);
    end
    #2;
    axi_areset = 1'b1;
    #1;
    n_tests++;
    if ({bus.s_axis_tready, bus.avg_bram_we, bus.fused_bram_we, bus.avg_bram_addr, bus.fused_bram_addr,
         bus.avg_bram_wdata, bus.fused_bram_wdata, bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast,
         bus.frame_idx, bus.frame_done, bus.tlast_err} !== '0) begin
      n_fail++;
      $display("FAIL midreset_async: got tready=%b mvalid=%b frame=%0d addr=%0d, required all 0",
               bus.s_axis_tready, bus.m_axis_tvalid, bus.frame_idx, bus.avg_bram_addr);
    end
    model_reset();
    @(posedge axi_clk);
    #1;
    axi_areset = 1'b0;
    @(posedge axi_clk);
    #1;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = rand_data();
    tick(acc, mhs);
    bus.s_axis_tvalid = 1'b0;
    n_tests++;
    if (acc !== 1'b1 || bus.avg_bram_addr !== '0 || bus.frame_idx !== '0) begin
      n_fail++;
      $display("FAIL midreset_restart: got acc=%b addr=%0d frame=%0d, required 1 0 0", acc, bus.avg_bram_addr, bus.frame_idx);
    end
  endtask

  task automatic test_tlast_check();
    logic acc, mhs;
    bus.m_axis_tready = 1'b1;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = rand_data();
    tl_force = 1'b1;
    tick(acc, mhs);
    tl_force = 1'b0;
    n_tests++;
    if (acc !== 1'b1 || bus.tlast_err !== EXP_ERR) begin
      n_fail++; $display("FAIL tlast_err_set: got acc=%b err=%b, required 1 %b", acc, bus.tlast_err, EXP_ERR);
    end
    for (int i = 0; i < 3; i++) begin
      bus.s_axis_tdata = rand_data();
      tick(acc, mhs);
    end
    bus.s_axis_tvalid = 1'b0;
    n_tests++;
    if (bus.tlast_err !== EXP_ERR) begin
      n_fail++; $display("FAIL tlast_err_sticky: got %b, required %b", bus.tlast_err, EXP_ERR);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_data_split();
    test_stall();
    test_back_to_back();
    test_reset_midframe();
    test_tlast_check();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
